// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage load/store initiator with read-modify-write
// for sub-doubleword stores. Optional watchdog: MEM_ACCESS_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misaligned,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_r_addr,
  output logic [ADDR_W-1:0] o_mem_w_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              err_set;
  logic              req_bad;
  logic              addr_mis;
  logic              timeout_hit;

  logic              req_we;
  logic [2:0]        req_f3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rdata_q;
  logic              misaligned_q;

  logic [5:0]        bit_off;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] merged;
  logic [7:0]        size_mask;
  logic [7:0]        byte_en;

  // Request legality is judged on the live inputs so a bad request never leaves IDLE.
  always_comb begin
    case (i_funct3[1:0])
      2'b01:   addr_mis = i_addr[0];
      2'b10:   addr_mis = |i_addr[1:0];
      2'b11:   addr_mis = |i_addr[2:0];
      default: addr_mis = 1'b0;
    endcase
    req_bad = addr_mis || (i_funct3 == 3'b111) || (i_we && i_funct3[2]);
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (state == S_RD || state == S_WR) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_req) begin
          if (req_bad) begin
            err_set = 1'b1;
          end else if (i_we && i_funct3[1:0] == 2'b11) begin
            state_nxt = S_WR;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        if (i_mem_valid) begin
          state_nxt = req_we ? S_WR : S_RESP;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
      end
      S_WR: begin
        if (i_mem_valid) begin
          state_nxt = S_RESP;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state == S_RD) || (state == S_WR);
    o_done      = (state == S_RESP);
    o_mem_read  = (state == S_RD);
    o_mem_write = (state == S_WR);
  end

  assign bit_off = {req_addr[2:0], 3'b000};

  // Load lane extraction and byte-exact store merge against the fetched doubleword.
  always_comb begin
    lane = i_mem_rdata >> bit_off;
    case (req_f3)
      3'b000:  load_val = {{(DATA_W-8){lane[7]}},   lane[7:0]};
      3'b001:  load_val = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      3'b010:  load_val = {{(DATA_W-32){lane[31]}}, lane[31:0]};
      3'b100:  load_val = {{(DATA_W-8){1'b0}},      lane[7:0]};
      3'b101:  load_val = {{(DATA_W-16){1'b0}},     lane[15:0]};
      3'b110:  load_val = {{(DATA_W-32){1'b0}},     lane[31:0]};
      default: load_val = lane;
    endcase

    case (req_f3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    byte_en  = size_mask << req_addr[2:0];
    wdata_sh = wr_data << bit_off;
    merged   = i_mem_rdata;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) begin
        merged[i*8 +: 8] = wdata_sh[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_we       <= 1'b0;
      req_f3       <= 3'b000;
      req_addr     <= '0;
      wr_data      <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= err_set;
      if (state == S_IDLE && i_req) begin
        req_we   <= i_we;
        req_f3   <= i_funct3;
        req_addr <= i_addr;
        if (i_we) begin
          wr_data <= i_wdata;
        end
      end
      if (state == S_RD && i_mem_valid) begin
        if (req_we) begin
          wr_data <= merged;
        end else begin
          rdata_q <= load_val;
        end
      end
    end
  end

  assign o_rdata      = rdata_q;
  assign o_misaligned = misaligned_q;
  assign o_mem_wdata  = wr_data;
  assign o_mem_r_addr = {req_addr[ADDR_W-1:3], 3'b000};
  assign o_mem_w_addr = {req_addr[ADDR_W-1:3], 3'b000};

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit : randomized self-checking bench with a byte-level
// reference memory model and a latency-programmable memory responder.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, misaligned, mem_read, mem_write;
  logic [63:0] rdata, mem_r_addr, mem_w_addr, mem_wdata;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] dmem [0:31];
  logic [7:0]  ref_bytes [0:255];
  int          max_delay = 0;
  bit          stall_wr = 1'b0;
  int          reads_seen = 0, writes_seen = 0;
  int          exp_reads = 0, exp_writes = 0;
  int          overlap = 0;
  logic [63:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done),
    .o_rdata(rdata), .o_misaligned(misaligned), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_mem_r_addr(mem_r_addr), .o_mem_w_addr(mem_w_addr),
    .o_mem_wdata(mem_wdata), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int base);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = v | (64'(ref_bytes[base + i]) << (8 * i));
    return v;
  endfunction

  // Memory: answers each strobe after a random number of wait cycles.
  initial begin
    int  cnt = 0;
    int  cur_delay = 0;
    bit  active = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (!active) begin
          active    = 1'b1;
          cnt       = 0;
          cur_delay = (max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0;
        end
        if (mem_write && stall_wr) begin
          mem_valid = 1'b0;
        end else if (cnt >= cur_delay) begin
          mem_valid = 1'b1;
          active    = 1'b0;
          if (mem_write) begin
            mem_rdata = {$urandom, $urandom};
            dmem[mem_w_addr[7:3]] = mem_wdata;
            writes_seen++;
          end else begin
            mem_rdata = dmem[mem_r_addr[7:3]];
            reads_seen++;
          end
        end else begin
          mem_valid = 1'b0;
          cnt++;
        end
      end else begin
        mem_valid = 1'b0;
        active    = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_read && mem_write) overlap++;
    end
  end

  task automatic do_req(input logic we_i, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output logic [63:0] rd_o);
    int          size;
    bit          bad;
    int          edges;
    int          exp_edges;
    logic [63:0] expv;
    size = 1 << f3[1:0];
    bad  = (f3 == 3'b111) || (we_i && f3 >= 3'd4) || ((a % size) != 0);
    @(negedge clk);
    req = 1'b1; we = we_i; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    edges = 1;
    if (bad) begin
      check_eq("mis_pulse", {63'd0, misaligned}, 64'd1);
      check_eq("mis_busy", {63'd0, busy}, 64'd0);
      check_eq("mis_strobe", {62'd0, mem_read, mem_write}, 64'd0);
      @(posedge clk);
      #1;
      check_eq("mis_one_cycle", {63'd0, misaligned}, 64'd0);
    end else begin
      check_eq("busy_set", {63'd0, busy}, 64'd1);
      while (!done && edges < 400) begin
        @(posedge clk);
        #1;
        edges++;
        if (misaligned) check_eq("spurious_mis", {63'd0, misaligned}, 64'd0);
      end
      check_eq("done_seen", {63'd0, done}, 64'd1);
      check_eq("busy_at_done", {63'd0, busy}, 64'd0);
      exp_edges = (we_i && size < 8) ? 3 : 2;
      if (max_delay == 0) check_eq("latency", 64'(edges), 64'(exp_edges));
      if (!(we_i && size == 8)) exp_reads++;
      if (we_i) exp_writes++;
      if (we_i) begin
        for (int i = 0; i < size; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
        check_eq("store_dword", dmem[a[7:3]], ref_dword(int'(a) & ~7));
      end else begin
        expv = '0;
        for (int i = 0; i < size; i++) expv = expv | (64'(ref_bytes[int'(a) + i]) << (8 * i));
        if (f3 < 3'd4 && size < 8 && expv[8*size-1]) expv = expv | (~64'd0 << (8 * size));
        exp_rdata = expv;
      end
      check_eq("rdata", rdata, exp_rdata);
      check_eq("reads", 64'(reads_seen), 64'(exp_reads));
      check_eq("writes", 64'(writes_seen), 64'(exp_writes));
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", {63'd0, done}, 64'd0);
    end
    rd_o = rdata;
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] old80;
    bit          saw_done;
    for (int i = 0; i < 32; i++) dmem[i] = {$urandom, $urandom};
    dmem[8] = 64'h8877665544332211;
    for (int i = 0; i < 256; i++) ref_bytes[i] = dmem[i / 8][8*(i % 8) +: 8];

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {59'd0, busy, done, misaligned, mem_read, mem_write}, 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    check_eq("rst_addr", mem_r_addr | mem_w_addr | mem_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_req(1'b0, 3'b000, 64'h47, 64'd0, r); check_eq("lb_47", r, 64'hFFFFFFFFFFFFFF88);
    do_req(1'b0, 3'b100, 64'h47, 64'd0, r); check_eq("lbu_47", r, 64'h88);
    do_req(1'b0, 3'b010, 64'h44, 64'd0, r); check_eq("lw_44", r, 64'hFFFFFFFF88776655);
    do_req(1'b0, 3'b110, 64'h44, 64'd0, r); check_eq("lwu_44", r, 64'h0000000088776655);
    do_req(1'b0, 3'b011, 64'h40, 64'd0, r); check_eq("ld_40", r, 64'h8877665544332211);
    do_req(1'b1, 3'b001, 64'h42, 64'hABCD, r);
    check_eq("sh_merge", dmem[8], 64'h88776655ABCD2211);
    do_req(1'b1, 3'b011, 64'h80, 64'h1122334455667788, r);
    check_eq("sd_80", dmem[16], 64'h1122334455667788);
    do_req(1'b0, 3'b001, 64'h41, 64'd0, r);
    do_req(1'b1, 3'b010, 64'h46, 64'd0, r);
    do_req(1'b0, 3'b111, 64'h40, 64'd0, r);

    // Reset while a store is waiting in WR: strobe drops immediately, no done.
    stall_wr = 1'b1;
    old80 = dmem[16];
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b011; addr = 64'h80; wdata = 64'hDEADBEEFCAFEF00D;
    @(posedge clk);
    #1;
    req = 1'b0;
    check_eq("wr_strobe", {63'd0, mem_write}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_wr_drop", {62'd0, mem_write, busy}, 64'd0);
    saw_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stall_wr = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check_eq("abort_no_done", {63'd0, saw_done}, 64'd0);
    check_eq("abort_mem", dmem[16], old80);
    check_eq("abort_rdata_clr", rdata, 64'd0);
    exp_rdata = 64'd0;
    do_req(1'b0, 3'b011, 64'h80, 64'd0, r);
    check_eq("ld_after_rst", r, 64'h1122334455667788);

    max_delay = 3;
    for (int n = 0; n < 250; n++) begin
      logic [2:0]  f3;
      logic [63:0] a;
      logic        w;
      f3 = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << f3[1:0]) - 64'd1);
      do_req(w, f3, a, {$urandom, $urandom}, r);
    end

    check_eq("rw_exclusive", 64'(overlap), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the data memory: accepts one load/store request from the pipeline, drives the memory's read/write strobes and addresses, and returns load data.
- Memory is byte-addressed but always transfers 8 bytes little-endian at the given address. This block issues doubleword-aligned accesses only.
- Sub-doubleword stores use read-modify-write. Loads are lane-extracted and sign- or zero-extended.
- Sits between the EX/MEM pipeline register and data memory. o_busy stalls the pipeline.

Parameters:
- ADDR_W, 64, address width (byte address).
- DATA_W, 64, data width; fixed at 64 (8 byte lanes).
- TIMEOUT_CYC, 16, watchdog limit in cycles (used only with the optional feature).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req  input  1  request strobe; sampled only in IDLE.
- i_we  input  1  1 = store, 0 = load.
- i_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 is illegal.
- i_addr  input  ADDR_W  byte address.
- i_wdata  input  DATA_W  store data, right-justified.
- o_busy  output  1  request in flight; pipeline stalls.
- o_done  output  1  one-cycle completion pulse.
- o_rdata  output  DATA_W  extended load result; held until the next load o_done.
- o_misaligned  output  1  one-cycle pulse: request rejected.
- o_mem_read  output  1  memory read strobe.
- o_mem_write  output  1  memory write strobe.
- o_mem_r_addr  output  ADDR_W  read address, always i_addr with [2:0]=0.
- o_mem_w_addr  output  ADDR_W  write address, always i_addr with [2:0]=0.
- o_mem_wdata  output  DATA_W  write data.
- i_mem_valid  input  1  memory access acknowledged/valid.
- i_mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset: all outputs 0, FSM = IDLE. Assertion mid-operation clears the strobes asynchronously and abandons the request; no o_done is issued.
- States: IDLE, RD, WR, RESP.
- IDLE, i_req=1:
  - Latch we, funct3, addr, wdata; set o_busy=1 the next cycle.
  - Misaligned or illegal request: pulse o_misaligned, set no strobe, stay IDLE. Misaligned means B never; H addr[0]≠0; W addr[1:0]≠0; D addr[2:0]≠0. Illegal means funct3=111, or a store with funct3 of 1xx.
  - Store with size D: go to WR.
  - Any other request: go to RD.
- RD:
  - o_mem_read=1, o_mem_r_addr = base (addr & ~7).
  - Wait for i_mem_valid=1 and capture i_mem_rdata.
  - Load: extract lane at byte offset addr[2:0], sign-extend (B/H/W) or zero-extend (BU/HU/WU/D), write o_rdata, go to RESP.
  - Store: merge wdata low bytes into the captured doubleword at offset, then go to WR.
- WR:
  - o_mem_write=1, o_mem_w_addr = base, o_mem_wdata = merged (or raw for D).
  - Wait for i_mem_valid=1, then go to RESP.
  - The strobe stays high for exactly the cycles spent in WR.
- RESP: o_done=1 for one cycle, o_busy=0 at the same edge, go to IDLE.
- o_mem_read and o_mem_write are never high in the same cycle.
- i_req while busy is ignored; the pipeline must hold the request stable until o_done.
- Latency with combinational valid:
  - Load: 3 cycles from request to o_done.
  - Store D: 3 cycles.
  - Sub-word store: 4 cycles.
- Merge is byte-exact: unaffected lanes are written back unchanged.
- i_mem_rdata is ignored while in WR.

Optional Feature:
- Macro MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RD/WR and clears on every state entry.
  - If i_mem_valid is not seen within TIMEOUT_CYC cycles, drop the strobes, pulse o_misaligned (repurposed as error), do not pulse o_done, and return to IDLE.
- Undefined: no counter; RD/WR wait indefinitely.

Test Plan:
- Memory doubleword at 0x40 = 0x8877665544332211. LB addr 0x47 -> o_rdata=0xFFFFFFFFFFFFFF88, o_done in 3rd cycle. LBU addr 0x47 -> 0x88.
- LW addr 0x44 -> 0xFFFFFFFF88776655. LWU -> 0x0000000088776655. LD 0x40 -> full value.
- SH wdata 0xABCD at 0x42 over 0x8877665544332211 -> one read at 0x40, then one write at 0x40 of 0x88776655ABCD2211. o_done after 4 cycles.
- SD 0x1122334455667788 at 0x80 -> no read strobe, write at 0x80, o_done after 3 cycles.
- LH at 0x41, SW at 0x46, funct3=111 -> o_misaligned one cycle, no strobe, o_busy stays 0.
- Assert i_rst during WR -> o_mem_write drops in the same cycle, no o_done. Next LD completes normally.
